// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the prioritized arbiter stage.
package prio_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index width for n inputs, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prioritized_arbiter_stage_ffs.sv
// Find-first-set over the request vector; the lowest index wins.
module prio_ffs
  import prio_arb_pkg::*;
#(
  parameter int n = 4
) (
  input  logic [n-1:0]          req,
  output logic [idx_w(n)-1:0]   idx,
  output logic                  found
);

  localparam int IW = idx_w(n);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prioritized_arbiter_stage.sv
// Registered, packet-aware fixed-priority arbiter (input 0 highest priority).
// PRIO_ARB_GRANT_INDEX_EN adds out_index, the input index of each output beat.
module prioritized_arbiter_stage
  import prio_arb_pkg::*;
#(
  parameter int data_width       = 8,
  parameter int number_of_inputs = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [number_of_inputs-1:0]   in_valid,
  input  logic [data_width-1:0]         in_data [number_of_inputs],
  input  logic [number_of_inputs-1:0]   in_last,
  output logic [number_of_inputs-1:0]   in_ready,
  output logic                          out_valid,
  output logic [data_width-1:0]         out_data,
  output logic                          out_last,
`ifdef PRIO_ARB_GRANT_INDEX_EN
  output logic [idx_w(number_of_inputs)-1:0] out_index,
`endif
  input  logic                          out_ready
);

  localparam int IW = idx_w(number_of_inputs);

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ffs_idx;
  logic          ffs_found;
  logic [IW-1:0] grant;
  logic          grant_valid;
  logic          slot_free;
  logic          xfer;

  prio_ffs #(.n(number_of_inputs)) u_ffs (
    .req   (in_valid),
    .idx   (ffs_idx),
    .found (ffs_found)
  );

  // While locked only the owner may be granted, even if it has gone idle.
  always_comb begin
    grant       = ffs_idx;
    grant_valid = ffs_found;
    if (state == LOCKED) begin
      grant       = owner;
      grant_valid = in_valid[owner];
    end
  end

  assign slot_free = !out_valid || out_ready;
  assign xfer      = grant_valid && slot_free;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef PRIO_ARB_GRANT_INDEX_EN
      out_index <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant];
      out_last  <= in_last[grant];
`ifdef PRIO_ARB_GRANT_INDEX_EN
      out_index <= grant;
`endif
      if (state == IDLE) begin
        if (!in_last[grant]) begin
          state <= LOCKED;
          owner <= grant;
        end
      end else if (in_last[grant]) begin
        state <= IDLE;
      end
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));
`endif

endmodule

// File: tb/tb_prioritized_arbiter_stage.sv
// Directed plus randomized bench for prioritized_arbiter_stage with a reference-model scoreboard.
module tb_prioritized_arbiter_stage;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] vld;
  logic [W-1:0] dat [N];
  logic [N-1:0] lst;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         ordy;
`ifdef PRIO_ARB_GRANT_INDEX_EN
  logic [1:0]   out_index;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic [1:0]   ix;
  } beat_t;
  beat_t sb[$];

  always #5 clk = ~clk;

  prioritized_arbiter_stage #(.data_width(W), .number_of_inputs(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld),
    .in_data   (dat),
    .in_last   (lst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef PRIO_ARB_GRANT_INDEX_EN
    .out_index (out_index),
`endif
    .out_ready (ordy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: checks ready/valid every cycle and scores every output beat.
  initial begin
    bit           m_locked;
    int           m_owner;
    bit           m_ov;
    bit           slot;
    int           g;
    logic [N-1:0] exp_rdy;
    beat_t        b;
    m_locked = 0; m_owner = 0; m_ov = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_locked = 0; m_owner = 0; m_ov = 0;
        sb.delete();
      end else begin
        slot = !m_ov || ordy;
        g = -1;
        if (m_locked) begin
          if (vld[m_owner]) g = m_owner;
        end else begin
          for (int i = N - 1; i >= 0; i--) if (vld[i]) g = i;
        end
        exp_rdy = '0;
        if (g >= 0 && slot) exp_rdy[g] = 1'b1;
        chk("mdl_in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
          end else begin
            chk("sb_data", 32'(out_data), 32'(sb[0].d));
            chk("sb_last", 32'(out_last), 32'(sb[0].l));
`ifdef PRIO_ARB_GRANT_INDEX_EN
            chk("sb_index", 32'(out_index), 32'(sb[0].ix));
`endif
            if (ordy) void'(sb.pop_front());
          end
        end
        if (exp_rdy != '0) begin
          b.d = dat[g]; b.l = lst[g]; b.ix = 2'(g);
          sb.push_back(b);
          m_ov = 1;
          if (!m_locked && !lst[g]) begin
            m_locked = 1;
            m_owner  = g;
          end else if (m_locked && lst[g]) begin
            m_locked = 0;
          end
        end else if (slot) begin
          m_ov = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; vld = '0; lst = '0; ordy = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = '0;
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Two single-beat requests, priority order.
    cyc(1); vld = 4'b1010; lst = 4'b1111; dat[1] = 8'h11; dat[3] = 8'h33;
    @(negedge clk); chk("t2_rdy_first", 32'(in_ready), 32'b0010);
    cyc(1); vld = 4'b1000;
    @(negedge clk); chk("t2_data_11", 32'(out_data), 32'h11);
    chk("t2_rdy_second", 32'(in_ready), 32'b1000);
    cyc(1); vld = '0;
    @(negedge clk); chk("t2_data_33", 32'(out_data), 32'h33);

    // Downstream stall for three cycles.
    cyc(1); vld = 4'b0001; dat[0] = 8'h55;
    cyc(1); vld = 4'b0010; dat[1] = 8'h66; ordy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_rdy", 32'(in_ready), 32'd0);
      chk("t4_stall_data", 32'(out_data), 32'h55);
      chk("t4_stall_valid", 32'(out_valid), 32'd1);
      cyc(1);
    end
    ordy = 1'b1;
    @(negedge clk); chk("t4_resume_rdy", 32'(in_ready), 32'b0010);
    cyc(1); vld = '0;
    @(negedge clk); chk("t4_data_66", 32'(out_data), 32'h66);

    // Three-beat packet on input 2; input 0 arrives mid-packet.
    cyc(1); vld = 4'b0100; lst = 4'b1011; dat[2] = 8'hA0;
    cyc(1); vld = 4'b0101; dat[2] = 8'hA1; dat[0] = 8'h0F;
    @(negedge clk); chk("t3_lock_rdy1", 32'(in_ready), 32'b0100);
    cyc(1); dat[2] = 8'hA2; lst = 4'b1111;
    @(negedge clk); chk("t3_lock_rdy2", 32'(in_ready), 32'b0100);
    chk("t3_data_a1", 32'(out_data), 32'hA1);
    cyc(1); vld = 4'b0001;
    @(negedge clk); chk("t3_release_rdy", 32'(in_ready), 32'b0001);
    chk("t3_data_a2", 32'(out_data), 32'hA2);
    chk("t3_last_a2", 32'(out_last), 32'd1);
    cyc(1); vld = '0;
    @(negedge clk); chk("t3_data_0f", 32'(out_data), 32'h0F);

    // Locked owner 1 goes idle for two cycles while input 0 requests.
    cyc(1); vld = 4'b0010; lst = 4'b1101; dat[1] = 8'hB0;
    cyc(1); vld = 4'b0001; dat[0] = 8'h0E;
    @(negedge clk); chk("t5_gap_rdy1", 32'(in_ready), 32'd0);
    chk("t5_b0_valid", 32'(out_valid), 32'd1);
    cyc(1);
    @(negedge clk); chk("t5_gap_rdy2", 32'(in_ready), 32'd0);
    chk("t5_drain1", 32'(out_valid), 32'd0);
    cyc(1); vld = 4'b0011; dat[1] = 8'hB1; lst = 4'b1111;
    @(negedge clk); chk("t5_drain2", 32'(out_valid), 32'd0);
    chk("t5_owner_rdy", 32'(in_ready), 32'b0010);
    cyc(1); vld = 4'b0001;
    @(negedge clk); chk("t5_data_b1", 32'(out_data), 32'hB1);
    chk("t5_rdy_in0", 32'(in_ready), 32'b0001);
    cyc(1); vld = '0;
    @(negedge clk); chk("t5_data_0e", 32'(out_data), 32'h0E);

    // Asynchronous reset in the middle of a locked packet.
    cyc(1); vld = 4'b0100; lst = 4'b1011; dat[2] = 8'hC0;
    cyc(1);
    #2 rst = 1'b1;
    #1 chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_data", 32'(out_data), 32'd0);
    cyc(1); rst = 1'b0; vld = 4'b0101; dat[0] = 8'hD0; lst = 4'b1111;
    @(negedge clk); chk("t1_post_rdy", 32'(in_ready), 32'b0001);
    cyc(1); vld = '0;
    @(negedge clk); chk("t1_data_d0", 32'(out_data), 32'hD0);

    // Grants 2, 0, 3 back to back.
    cyc(1); vld = 4'b0100; dat[2] = 8'hE2; lst = 4'b1111;
    cyc(1); vld = 4'b0001; dat[0] = 8'hE0;
    @(negedge clk); chk("t6_data_e2", 32'(out_data), 32'hE2);
    cyc(1); vld = 4'b1000; dat[3] = 8'hE3;
    @(negedge clk); chk("t6_data_e0", 32'(out_data), 32'hE0);
    cyc(1); vld = '0;
    @(negedge clk); chk("t6_data_e3", 32'(out_data), 32'hE3);

    // Random traffic with backpressure, scored by the model.
    for (int k = 0; k < 300; k++) begin
      cyc(1);
      vld  = 4'($urandom);
      lst  = 4'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < N; j++) dat[j] = 8'($urandom);
    end
    cyc(1); vld = '0; ordy = 1'b1;
    cyc(3);
    @(negedge clk); chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
